// File: rtl/interface_hcsr04_param_if.sv
// Handshake and sensor-pin bundle between the sonar top level and the HC-SR04 interface.
interface interface_hcsr04_param_if #(
    parameter int DIST_W = 12
);
    logic              medir;
    logic              echo;
    logic              trigger;
    logic [DIST_W-1:0] medida;
    logic [1:0]        erro;
    logic              pronto;
    logic              ocupado;
    logic [3:0]        db_estado;

    modport slave (
        input  medir, echo,
        output trigger, medida, erro, pronto, ocupado, db_estado
    );

    modport master (
        output medir, echo,
        input  trigger, medida, erro, pronto, ocupado, db_estado
    );
endinterface

// File: rtl/interface_hcsr04_param.sv
// HC-SR04 controller: trigger generation, echo synchronisation, echo-width to cm conversion
// and missing/overlong echo fault reporting.
//
// state    | meaning
// INICIAL  | idle, waiting for medir
// PREPARA  | clear counters, load trigger timer
// TRIGGER  | trigger pin high for TRIG_CYC cycles
// ESPERA   | waiting for echo rising edge (wait timeout)
// MEDIDA   | echo high, counting ticks/cm (echo timeout)
// ARMAZENA | latch distance, clear error
// FALHA    | latch error code, keep old distance
// FIM      | one-cycle pronto
module interface_hcsr04_param #(
    parameter int TRIG_CYC     = 500,
    parameter int TICKS_PER_CM = 2941,
    parameter int DIST_W       = 12,
    parameter int WAIT_TIMEOUT = 1_250_000,
    parameter int ECHO_TIMEOUT = 1_900_000
) (
    input  logic                         clock,
    input  logic                         reset,
    interface_hcsr04_param_if.slave      bus
);

    localparam int TMR_MAX_A = (TRIG_CYC > WAIT_TIMEOUT) ? TRIG_CYC : WAIT_TIMEOUT;
    localparam int TMR_MAX   = (TMR_MAX_A > ECHO_TIMEOUT) ? TMR_MAX_A : ECHO_TIMEOUT;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int TICK_W    = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

    localparam logic [TMR_W-1:0]  TMR_TRIG = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_WAIT = TMR_W'(WAIT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_ECHO = TMR_W'(ECHO_TIMEOUT - 1);
    localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICKS_PER_CM - 1);
    localparam logic [DIST_W-1:0] DIST_SAT = {DIST_W{1'b1}};

    typedef enum logic [3:0] {
        S_INICIAL  = 4'b0000,
        S_PREPARA  = 4'b0001,
        S_TRIGGER  = 4'b0010,
        S_ESPERA   = 4'b0011,
        S_MEDIDA   = 4'b0100,
        S_ARMAZENA = 4'b0101,
        S_FALHA    = 4'b1110,
        S_FIM      = 4'b1111
    } state_t;

    state_t              state_q,     state_d;
    logic [TMR_W-1:0]    tmr_q,       tmr_d;
    logic [TICK_W-1:0]   tick_q,      tick_d;
    logic [DIST_W-1:0]   dist_q,      dist_d;
    logic [1:0]          code_q,      code_d;
    logic [DIST_W-1:0]   medida_q,    medida_d;
    logic [1:0]          erro_q,      erro_d;
    logic                echo_meta_q, echo_meta_d;
    logic                echo_s_q,    echo_s_d;
    logic                echo_prev_q, echo_prev_d;

    logic echo_rise;
    logic echo_fall;
    logic count_en;

    assign echo_rise = echo_s_q & ~echo_prev_q;
    assign echo_fall = ~echo_s_q & echo_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_INICIAL;
            tmr_q       <= '0;
            tick_q      <= '0;
            dist_q      <= '0;
            code_q      <= '0;
            medida_q    <= '0;
            erro_q      <= '0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            tick_q      <= tick_d;
            dist_q      <= dist_d;
            code_q      <= code_d;
            medida_q    <= medida_d;
            erro_q      <= erro_d;
            echo_meta_q <= echo_meta_d;
            echo_s_q    <= echo_s_d;
            echo_prev_q <= echo_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        tick_d      = tick_q;
        dist_d      = dist_q;
        code_d      = code_q;
        medida_d    = medida_q;
        erro_d      = erro_q;
        echo_meta_d = bus.echo;
        echo_s_d    = echo_meta_q;
        echo_prev_d = echo_s_q;
        count_en    = 1'b0;

        case (state_q)
            S_INICIAL: begin
                if (bus.medir) state_d = S_PREPARA;
            end
            S_PREPARA: begin
                tmr_d   = TMR_TRIG;
                tick_d  = '0;
                dist_d  = '0;
                code_d  = 2'b00;
                state_d = S_TRIGGER;
            end
            S_TRIGGER: begin
                if (tmr_q == '0) begin
                    tmr_d   = TMR_WAIT;
                    state_d = S_ESPERA;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_ESPERA: begin
                // The rise cycle already has echo_s high, so it is counted here.
                if (echo_rise) begin
                    count_en = 1'b1;
                    tmr_d    = TMR_ECHO;
                    state_d  = S_MEDIDA;
                end else if (tmr_q == '0) begin
                    code_d  = 2'b01;
                    state_d = S_FALHA;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_MEDIDA: begin
                count_en = echo_s_q;
                if (echo_fall) begin
                    state_d = S_ARMAZENA;
                end else if (tmr_q == '0) begin
                    code_d  = 2'b10;
                    state_d = S_FALHA;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_ARMAZENA: begin
                medida_d = dist_q;
                erro_d   = 2'b00;
                state_d  = S_FIM;
            end
            S_FALHA: begin
                erro_d  = code_q;
                state_d = S_FIM;
            end
            S_FIM: begin
                state_d = S_INICIAL;
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase

        if (count_en) begin
            if (tick_q == TICK_TOP) begin
                tick_d = '0;
                if (dist_q != DIST_SAT) dist_d = dist_q + DIST_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    assign bus.trigger   = (state_q == S_TRIGGER);
    assign bus.pronto    = (state_q == S_FIM);
    assign bus.ocupado   = (state_q != S_INICIAL);
    assign bus.db_estado = state_q;
    assign bus.medida    = medida_q;
    assign bus.erro      = erro_q;

endmodule
